// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage divider: FSM encodings, stall-request values
// and the reset polarity.
package ex_div_pkg;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_RUN  = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    // Level of start_i that requests a division
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Values driven on the stall-request line to the pipeline controller
    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Reset is active-low
    localparam logic RSTENABLE = 1'b0;

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quo_bit_o
);

    logic [WIDTH:0] shifted;

    // Shifted partial remainder is WIDTH+1 bits; the compare is the sign test of the
    // trial subtraction, and a kept difference is always below the divisor.
    always_comb begin
        shifted   = {rem_i, bit_i};
        quo_bit_o = (shifted >= {1'b0, divisor_i});
        rem_o     = quo_bit_o ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage. Holds the pipeline
// via stallreq_o until {remainder, quotient} is valid on result_o.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic [WIDTH-1:0]   dvd_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   dvs_q;      // divisor magnitude
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH-1:0]   step_rem;
    logic               step_bit;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_bit_o (step_bit)
    );

    // Operand magnitudes at latch time and sign fix-up of the final step's result
    always_comb begin
        op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
        op1_mag  = op1_neg ? negate(opdata1_i) : opdata1_i;
        op2_mag  = op2_neg ? negate(opdata2_i) : opdata2_i;
        quo_next = {dvd_q[WIDTH-2:0], step_bit};
        quo_fix  = neg_quo_q ? negate(quo_next) : quo_next;
        rem_fix  = neg_rem_q ? negate(step_rem) : step_rem;
    end

    // Divider FSM with registered result/ready; annul_i overrides every state
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTENABLE) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else if (annul_i) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    if (start_i == DIV_START) begin
                        rem_q     <= '0;
                        dvd_q     <= op1_mag;
                        dvs_q     <= op2_mag;
                        neg_quo_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                        cnt_q     <= '0;
                        state_q   <= (opdata2_i == '0) ? DIV_ZERO : DIV_RUN;
                    end
                end
                DIV_ZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= DIV_DONE;
                end
                DIV_RUN: begin
                    rem_q <= step_rem;
                    dvd_q <= quo_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Final step publishes the sign-fixed result directly so ready_o
                    // rises WIDTH cycles after the start edge.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                        state_q  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (start_i == DIV_STOP) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

    // Stall immediately on start; release in the cycle the result appears.
    // Held low while reset is asserted so the controller sees no stall during reset.
    assign stallreq_o = ((rst != RSTENABLE) && (start_i == DIV_START) && !ready_q && !annul_i)
                        ? STOP : NOSTOP;

endmodule
